rmser_8: RTL and testbench

- Eight-channel running mean-square (power) estimator for the Intan RHD2216 acquisition path.
- Sits between the per-frame sample latch (eight 16-bit electrode values plus a frame trigger) and the Bluetooth/display formatters.
- Per channel, it removes DC with a first-order IIR high-pass, squares the result, and smooths the square with a leaky integrator.
- All eight results are presented together with a data-ready pulse.

---
 rtl/rmser_8_pkg.sv | 19 +
 rtl/rmser_8_if.sv | 16 +
 rtl/rmser_8_ms_channel_math.sv | 57 +++++
 rtl/rmser_8.sv | 129 ++++++++++++
 tb/tb_rmser_8.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/rmser_8_pkg.sv
// Shared types and widths for the eight-channel running mean-square estimator.
package rmser_8_pkg;

  localparam int unsigned NCH      = 8;
  localparam int unsigned CH_W     = $clog2(NCH);
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned M_W      = 32;
  localparam int unsigned P_W      = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_HP,
    ST_SQ,
    ST_ACC,
    ST_DONE
  } state_e;

endpackage

// File: rtl/rmser_8_if.sv
// Sample/result bus between the frame latch, the estimator and the formatters.
//   trigger : frame-ready level (asynchronous to clk)
//   x       : eight signed 16-bit samples, x[0] = X1
//   ms      : eight unsigned 16-bit mean-square results, ms[0] = MS1
//   dr      : data-ready pulse
interface rmser_8_if;
  import rmser_8_pkg::*;

  logic                               trigger;
  logic [NCH-1:0][SAMPLE_W-1:0]       x;
  logic [NCH-1:0][SAMPLE_W-1:0]       ms;
  logic                               dr;

  modport master (output trigger, output x, input ms, input dr);
  modport slave  (input trigger, input x, output ms, output dr);
endinterface

// File: rtl/rmser_8_ms_channel_math.sv
// Combinational datapath for one channel step: DC-removing high-pass,
// scaled saturating square and leaky-integrator update.
//   x, m      -> m_next_c, hp_c      (HP step)
//   hp_in     -> sqs_c               (SQ step, the single shared multiplier)
//   p, sqs_in -> p_next_c, r_c       (ACC step)
module rmser_8_ms_channel_math
  import rmser_8_pkg::*;
#(
  parameter int unsigned HP_SHIFT = 8,
  parameter int unsigned SQ_SHIFT = 8,
  parameter int unsigned LP_SHIFT = 6
) (
  input  logic signed [SAMPLE_W-1:0] x,
  input  logic signed [M_W-1:0]      m,
  input  logic signed [SAMPLE_W-1:0] hp_in,
  input  logic        [P_W-1:0]      p,
  input  logic        [SAMPLE_W-1:0] sqs_in,
  output logic signed [M_W-1:0]      m_next_c,
  output logic signed [SAMPLE_W-1:0] hp_c,
  output logic        [SAMPLE_W-1:0] sqs_c,
  output logic        [P_W-1:0]      p_next_c,
  output logic        [SAMPLE_W-1:0] r_c
);

  logic signed [M_W-1:0] mean;
  logic signed [M_W-1:0] diff;
  logic signed [16:0]    diff17;
  logic signed [31:0]    prod;
  logic        [31:0]    sq_sh;

  // High-pass: DC tracker keeps the full difference, output is saturated
  always_comb begin
    mean     = m >>> HP_SHIFT;
    diff     = 32'(x) - mean;
    diff17   = 17'(x) - 17'(mean);
    m_next_c = m + diff;
    if (diff17[16] != diff17[15]) begin
      hp_c = diff17[16] ? 16'sh8000 : 16'sh7fff;
    end else begin
      hp_c = diff17[15:0];
    end
  end

  // Square, scale down, clamp to 16 bits
  always_comb begin
    prod  = hp_in * hp_in;
    sq_sh = $unsigned(prod) >> SQ_SHIFT;
    sqs_c = (|sq_sh[31:16]) ? 16'hffff : sq_sh[15:0];
  end

  // Leaky integrator and its scaled readout
  always_comb begin
    p_next_c = p + 24'(sqs_in) - (p >> LP_SHIFT);
    r_c      = 16'(p_next_c >> LP_SHIFT);
  end

endmodule

// File: rtl/rmser_8.sv
// Eight-channel running mean-square estimator.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : slave side of rmser_8_if (trigger/x in, ms/dr out)
// A synchronized rising edge of trigger snapshots all samples, then each
// channel is processed in three cycles (HP, SQ, ACC) on one shared datapath.
// All results are published together with a DR_WIDTH-cycle dr pulse.
module rmser_8
  import rmser_8_pkg::*;
#(
  parameter int unsigned HP_SHIFT = 8,
  parameter int unsigned LP_SHIFT = 6,
  parameter int unsigned SQ_SHIFT = 8,
  parameter int unsigned DR_WIDTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  rmser_8_if.slave  bus
);

  localparam int unsigned DRC_W = $clog2(DR_WIDTH + 1);

  logic sync1, sync2, sync3;
  logic rise_c;

  state_e state, state_n;

  logic [CH_W-1:0]               ch;
  logic [DRC_W-1:0]              dr_cnt;
  logic [NCH-1:0][SAMPLE_W-1:0]  x_snap;
  logic [NCH-1:0][SAMPLE_W-1:0]  staging;
  logic signed [M_W-1:0]         m_arr [NCH];
  logic [P_W-1:0]                p_arr [NCH];
  logic signed [SAMPLE_W-1:0]    hp_r;
  logic [SAMPLE_W-1:0]           sqs_r;

  logic signed [M_W-1:0]         m_next_c;
  logic signed [SAMPLE_W-1:0]    hp_c;
  logic [SAMPLE_W-1:0]           sqs_c;
  logic [P_W-1:0]                p_next_c;
  logic [SAMPLE_W-1:0]           r_c;

  assign rise_c = sync2 & ~sync3;

  rmser_8_ms_channel_math #(
    .HP_SHIFT (HP_SHIFT),
    .SQ_SHIFT (SQ_SHIFT),
    .LP_SHIFT (LP_SHIFT)
  ) u_math (
    .x        ($signed(x_snap[ch])),
    .m        (m_arr[ch]),
    .hp_in    (hp_r),
    .p        (p_arr[ch]),
    .sqs_in   (sqs_r),
    .m_next_c (m_next_c),
    .hp_c     (hp_c),
    .sqs_c    (sqs_c),
    .p_next_c (p_next_c),
    .r_c      (r_c)
  );

  // Next-state logic; edges seen outside IDLE are dropped
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    if (rise_c) state_n = ST_CAPTURE;
      ST_CAPTURE: state_n = ST_HP;
      ST_HP:      state_n = ST_SQ;
      ST_SQ:      state_n = ST_ACC;
      ST_ACC:     state_n = (ch == CH_W'(NCH - 1)) ? ST_DONE : ST_HP;
      ST_DONE:    if (dr_cnt == DRC_W'(DR_WIDTH - 1)) state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  // State, synchronizer, per-channel accumulators and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync3   <= 1'b0;
      state   <= ST_IDLE;
      ch      <= '0;
      dr_cnt  <= '0;
      x_snap  <= '0;
      staging <= '0;
      hp_r    <= '0;
      sqs_r   <= '0;
      bus.ms  <= '0;
      bus.dr  <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
        m_arr[i] <= '0;
        p_arr[i] <= '0;
      end
    end else begin
      sync1 <= bus.trigger;
      sync2 <= sync1;
      sync3 <= sync2;
      state <= state_n;
      case (state)
        ST_CAPTURE: begin
          x_snap <= bus.x;
          ch     <= '0;
        end
        ST_HP: begin
          m_arr[ch] <= m_next_c;
          hp_r      <= hp_c;
        end
        ST_SQ: sqs_r <= sqs_c;
        ST_ACC: begin
          p_arr[ch]   <= p_next_c;
          staging[ch] <= r_c;
          ch          <= ch + CH_W'(1);
          dr_cnt      <= '0;
        end
        ST_DONE: dr_cnt <= dr_cnt + DRC_W'(1);
        default: ;
      endcase
      // Publish on entry to DONE; the last channel's result bypasses staging
      if (state == ST_ACC && state_n == ST_DONE) begin
        for (int unsigned i = 0; i < NCH; i++) begin
          bus.ms[i] <= (CH_W'(i) == ch) ? r_c : staging[i];
        end
      end
      bus.dr <= (state_n == ST_DONE);
    end
  end

endmodule

// File: tb/tb_rmser_8.sv
// Randomized self-checking bench for rmser_8 against a frame-level model.
module tb_rmser_8;
  import rmser_8_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rmser_8_if bus_if ();

  rmser_8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int     n_cmp = 0;
  int     n_err = 0;
  int     xs     [NCH];
  int     m_mdl  [NCH];
  longint p_mdl  [NCH];
  int     ms_exp [NCH];

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_mdl[i]  = 0;
      p_mdl[i]  = 0;
      ms_exp[i] = 0;
    end
  endfunction

  // One frame of the estimator, computed from the arithmetic definition
  function automatic void model_frame();
    for (int i = 0; i < NCH; i++) begin
      int     mean;
      int     d;
      int     hp;
      longint sqs;
      mean = m_mdl[i] >>> 8;
      d    = xs[i] - mean;
      hp   = (d > 32767) ? 32767 : ((d < -32768) ? -32768 : d);
      m_mdl[i] = m_mdl[i] + d;
      sqs  = (longint'(hp) * longint'(hp)) / 256;
      if (sqs > 65535) sqs = 65535;
      p_mdl[i]  = p_mdl[i] + sqs - (p_mdl[i] / 64);
      ms_exp[i] = int'((p_mdl[i] / 64) % 65536);
    end
  endfunction

  function automatic int rand_sample();
    case ($urandom_range(0, 3))
      0:       return -32768;
      1:       return 32767;
      2:       return int'($urandom_range(0, 2000)) - 1000;
      default: return int'($signed(16'($urandom)));
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus_if.trigger = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Drive one trigger and watch n_cyc cycles; optional re-trigger / mid-frame reset
  task automatic run_frame(input int n_cyc, input int retrig_at, input int rst_at);
    int   first_hi = -1;
    int   hi_cnt   = 0;
    int   rises    = 0;
    logic prev     = 1'b0;
    logic held     = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NCH; i++) bus_if.x[i] = 16'(xs[i]);
    bus_if.trigger = 1'b1;
    for (int k = 1; k <= n_cyc; k++) begin
      @(negedge clk);
      if (bus_if.dr && !prev) begin
        rises++;
        if (first_hi < 0) first_hi = k;
      end
      if (bus_if.dr) hi_cnt++;
      prev = bus_if.dr;
      if (first_hi < 0 && rst_at < 0) begin
        for (int i = 0; i < NCH; i++)
          if (int'(bus_if.ms[i]) != ms_exp[i]) held = 1'b0;
      end
      if (k == 4) bus_if.trigger = 1'b0;
      if (retrig_at > 0 && k == retrig_at) bus_if.trigger = 1'b1;
      if (retrig_at > 0 && k == retrig_at + 4) bus_if.trigger = 1'b0;
      if (rst_at > 0 && k == rst_at) rst = 1'b1;
      if (rst_at > 0 && k == rst_at + 1) rst = 1'b0;
    end
    if (rst_at > 0) begin
      model_reset();
      check_eq("abort_dr_pulses", rises, 0);
      for (int i = 0; i < NCH; i++)
        check_eq($sformatf("abort_ms%0d", i + 1), bus_if.ms[i], 0);
    end else begin
      check_eq("ms_hold_before_dr", held, 1);
      model_frame();
      // trigger driven mid-cycle: sync edge flagged 2 edges later, DR at E+26
      check_eq("dr_latency", first_hi, 28);
      check_eq("dr_width", hi_cnt, 4);
      check_eq("dr_pulses", rises, 1);
      for (int i = 0; i < NCH; i++)
        check_eq($sformatf("ms%0d", i + 1), bus_if.ms[i], ms_exp[i]);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus_if.trigger = 1'b0;
    bus_if.x = '0;
    for (int i = 0; i < NCH; i++) xs[i] = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("reset_dr", bus_if.dr, 0);
    for (int i = 0; i < NCH; i++)
      check_eq($sformatf("reset_ms%0d", i + 1), bus_if.ms[i], 0);
    rst = 1'b0;

    // all-zero frame
    run_frame(32, -1, -1);

    // single positive step on channel 0
    do_reset();
    for (int i = 0; i < NCH; i++) xs[i] = 0;
    xs[0] = 256;
    run_frame(32, -1, -1);
    check_eq("ms1_step256", bus_if.ms[0], 4);

    // full-scale negative sample saturates the scaled square
    do_reset();
    for (int i = 0; i < NCH; i++) xs[i] = 0;
    xs[2] = -32768;
    run_frame(32, -1, -1);
    check_eq("ms3_sat_first", bus_if.ms[2], 1023);
    run_frame(32, -1, -1);
    check_eq("ms3_sat_second", bus_if.ms[2], 2031);

    // random frames
    do_reset();
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < NCH; i++) xs[i] = rand_sample();
      run_frame(32, -1, -1);
    end

    // second edge while busy is dropped
    for (int i = 0; i < NCH; i++) xs[i] = rand_sample();
    run_frame(64, 10, -1);

    // reset mid-update, then a clean first frame
    for (int i = 0; i < NCH; i++) xs[i] = rand_sample();
    run_frame(32, -1, 16);
    for (int i = 0; i < NCH; i++) xs[i] = rand_sample();
    run_frame(32, -1, -1);

    // long run: alternating tone on channel 0, constant DC on channel 1
    do_reset();
    for (int i = 0; i < NCH; i++) xs[i] = 0;
    xs[1] = 5000;
    for (int f = 0; f < 1700; f++) begin
      xs[0] = (f % 2 == 0) ? 1024 : -1024;
      run_frame(32, -1, -1);
    end
    check_eq("ms1_settled_2pct", (bus_if.ms[0] >= 16'd4014 && bus_if.ms[0] <= 16'd4178), 1);
    check_eq("ms2_dc_decayed", (bus_if.ms[1] < 16'd2), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
